uart_rx_core: RTL
=================

# uart_rx_core

Serial receive front end of the AXI4-Lite-to-UART bridge. It samples the asynchronous `rx` line, recovers 8N1 frames (8E1/8O1 when parity is compiled in), and delivers each good byte as a one-cycle write strobe into the receive byte FIFO. The FIFO's read side feeds the 8-to-32-bit receive assembly stage. The core has no backpressure; overflow handling belongs to the FIFO.

## Interface
- `CLK_DIV`, 434, clk cycles per bit (50 MHz / 115200); legal range 4..65535.
- `PARITY_ODD`, 0, 0 = even parity, 1 = odd parity; used only when `UART_RX_PARITY_EN` is defined.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `rx`  in  1  serial line, idle high, asynchronous to `clk`.
- `rx_data`  out  8  last received byte; reset 0; changes only together with `rx_valid`.
- `rx_valid`  out  1  one-cycle strobe, `rx_data` valid (FIFO write enable); reset 0.
- `frame_err`  out  1  one-cycle strobe, stop bit sampled low; reset 0.
- `parity_err`  out  1  one-cycle strobe, parity mismatch; reset 0; tied 0 without macro.
- `busy`  out  1  high in every state except IDLE; reset 0.

## Operation
- `rx` passes through a 2-flop synchronizer, both flops reset to 1; the output is `rx_s`. All logic uses `rx_s`.
- Bit timer: down-counter, width $clog2(CLK_DIV); "tick" = counter equals 0.
- States: IDLE, START, DATA, PARITY (macro only), STOP.
- IDLE: a falling edge of `rx_s` (previous 1, current 0) loads the counter with CLK_DIV/2-1 (integer division) and moves to START.
- START: on tick, if `rx_s`=0, load CLK_DIV-1, clear bit index, go to DATA. If `rx_s`=1, treat it as a glitch and return to IDLE with no strobe.
- DATA: on each tick, shift `rx_s` in LSB-first and reload CLK_DIV-1. After the 8th bit, go to PARITY (macro) or STOP.
- PARITY: on tick, compare `rx_s` with the expected bit (XOR of data, inverted if PARITY_ODD), latch the mismatch, reload, go to STOP.
- STOP: on tick, sample `rx_s`:
  - Sampled 1, parity OK: `rx_data` <= shift register, pulse `rx_valid`.
  - Sampled 1, parity bad: pulse `parity_err` only; `rx_data` is held.
  - Sampled 0: pulse `frame_err` only; parity result is discarded.
  - All cases return to IDLE.
- A line held low after a frame error (break) does not retrigger, because IDLE needs a fresh falling edge.
- Strobes are mutually exclusive and never last longer than one cycle.
- Reset mid-frame: all state is discarded, outputs return to reset values, and no strobe is produced. After reset, `rx_s` powers up at 1, so a line that is already low is not seen as a start bit.

## Timing
- Let t0 be the clk edge at which `rx_s` first reads 0. That is 2 cycles after the `rx` transition, with ±1 cycle of synchronizer uncertainty.
- Start bit is sampled at t0 + CLK_DIV/2.
- Data bit i (i = 0..7) is sampled at t0 + CLK_DIV/2 + (i+1)·CLK_DIV.
- Stop bit is sampled at t0 + CLK_DIV/2 + 9·CLK_DIV, or + 10·CLK_DIV with parity.
- `rx_valid`, `frame_err` and `parity_err` are registered. They are high during the cycle after the stop-sample edge.
- The core returns to IDLE on that same edge, so a start bit immediately following the stop bit is accepted. Back-to-back frames give one strobe per frame with no gap requirement.
- Tolerated baud mismatch is about ±4%, since sampling is at mid-bit.

## Configuration
- `UART_RX_PARITY_EN` defined: PARITY state present, frame is 11 bits, `parity_err` is live, and `PARITY_ODD` selects the sense.
- Not defined: frame is 8N1 (10 bits), there is no PARITY state, and `parity_err` is constant 0.

## Test plan
All scenarios use CLK_DIV=16.
- Reset held low for 3 cycles, then released with `rx`=1 -> all outputs 0 and the core stays in IDLE for 1000 cycles.
- Frame with byte 0xA5, stop=1 -> `rx_data`=0xA5 and `rx_valid` high for exactly 1 cycle, 2+8+144 (±1) cycles after the `rx` start edge. `busy` is high from t0 until the strobe.
- Three back-to-back frames 0x00, 0xFF, 0x3C with no idle gap -> three `rx_valid` pulses 160 cycles apart with matching data. No errors.
- Frame 0x55 with stop bit driven 0, then line held low for 200 cycles and released -> a single `frame_err` pulse, no `rx_valid`, `rx_data` unchanged. The next good frame 0x12 is received correctly.
- Low glitch of 5 cycles on idle `rx` -> no strobe and a return to IDLE. Separately: reset asserted during data bit 4 of 0x81 -> no strobe and outputs zeroed; the following frame 0x81 is received correctly.
- With `UART_RX_PARITY_EN` and PARITY_ODD=0:
  - Frame 0x07 with parity bit 1 -> `rx_valid` with 0x07.
  - Same frame with parity bit 0 -> `parity_err` pulse only.
  - Without the macro, an 8N1 frame 0x07 -> `rx_valid`, and `parity_err` stays 0 throughout.

Source files
------------

// File: rtl/uart_rx_core.sv
// ---------------------------------------------------------------------------
// uart_rx_core
//   Serial receive front end of the AXI4-Lite-to-UART bridge. It synchronises
//   the asynchronous rx line, recovers 8N1 frames, and emits every good byte as
//   a one-cycle write strobe for the receive byte FIFO. There is no
//   backpressure; overflow handling is the FIFO's job.
//
//   Compile-time option:
//     UART_RX_PARITY_EN  - adds a parity bit (8E1 / 8O1, selected by
//                          PARITY_ODD). Without it the frame is 8N1 and
//                          parity_err is tied low.
//
// Parameters
//   CLK_DIV     clk cycles per bit, 4..65535 (434 = 50 MHz / 115200)
//   PARITY_ODD  0 = even parity, 1 = odd parity (parity build only)
//
// Ports
//   clk         clock
//   rst         asynchronous active-low reset
//   rx          serial line, idle high, asynchronous to clk
//   rx_data     last good byte; only changes together with rx_valid
//   rx_valid    one-cycle strobe: rx_data holds a new byte (FIFO write enable)
//   frame_err   one-cycle strobe: stop bit sampled low
//   parity_err  one-cycle strobe: parity mismatch (0 in the 8N1 build)
//   busy        high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx_core #(
  parameter int CLK_DIV    = 434,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int TW = $clog2(CLK_DIV);
  // First wait is half a bit so every later sample lands mid-bit.
  localparam logic [TW-1:0] HALF_LOAD = TW'(CLK_DIV / 2 - 1);
  localparam logic [TW-1:0] FULL_LOAD = TW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  // -------------------------------------------------------------------------
  // Input synchroniser. All stages reset to the idle level so a line that is
  // already low when reset releases is not mistaken for a start bit.
  // rx_prev_q is one more delay so IDLE can look for a 1 -> 0 transition.
  // -------------------------------------------------------------------------
  logic sync1_q;
  logic rx_s_q;
  logic rx_prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= rx;
      rx_s_q    <= sync1_q;
      rx_prev_q <= rx_s_q;
    end
  end

  // -------------------------------------------------------------------------
  // Receiver state
  // -------------------------------------------------------------------------
  state_t        state_q,   state_d;
  logic [TW-1:0] timer_q,   timer_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q,   shift_d;
  logic [7:0]    data_q,    data_d;
  logic          valid_q,   valid_d;
  logic          ferr_q,    ferr_d;
`ifdef UART_RX_PARITY_EN
  localparam logic ODD_BIT = (PARITY_ODD != 0);
  logic          par_bad_q, par_bad_d;
  logic          perr_q,    perr_d;
`else
  // PARITY_ODD has no effect in the 8N1 build.
  logic          unused_parity_cfg;
  assign unused_parity_cfg = (PARITY_ODD != 0);
`endif

  logic tick;
  assign tick = (timer_q == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = 1'b0;
`endif

    // Free-running count-down while a frame is in progress; each state
    // reloads it on its own tick.
    if (state_q != S_IDLE && !tick) begin
      timer_d = timer_q - TW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (rx_prev_q && !rx_s_q) begin
          timer_d = HALF_LOAD;
          state_d = S_START;
        end
      end

      S_START: begin
        if (tick) begin
          if (!rx_s_q) begin
            timer_d   = FULL_LOAD;
            bit_idx_d = 3'd0;
            state_d   = S_DATA;
          end else begin
            // Line went back high before mid-bit: a glitch, not a start bit.
            state_d = S_IDLE;
          end
        end
      end

      S_DATA: begin
        if (tick) begin
          shift_d   = {rx_s_q, shift_q[7:1]};   // LSB arrives first
          timer_d   = FULL_LOAD;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          // Mismatch when the received bit differs from XOR(data)^ODD.
          par_bad_d = rx_s_q ^ (^shift_q) ^ ODD_BIT;
          timer_d   = FULL_LOAD;
          state_d   = S_STOP;
        end
      end
`endif

      S_STOP: begin
        if (tick) begin
          // Returning to IDLE on this edge lets a start bit that follows
          // the stop bit immediately be caught.
          state_d = S_IDLE;
          if (!rx_s_q) begin
            ferr_d = 1'b1;            // framing error wins over parity
`ifdef UART_RX_PARITY_EN
          end else if (par_bad_q) begin
            perr_d = 1'b1;            // bad byte is not delivered
`endif
          end else begin
            valid_d = 1'b1;
            data_d  = shift_q;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule
